// File: rtl/fp_to_int_pkg.sv
// Shared definitions for the FP-to-integer exit converter.
// Holds the exception-field codes, the converter state encoding, the operand
// classification produced by the field decoder, and the default field layout
// of the internal FP word:
//   [size-1 : size-2]            exception
//   [size-3]                     sign
//   [size-4 : size_mantissa-1]   biased exponent
//   [size_mantissa-2 : 0]        fraction (hidden bit implied)
package fp_to_int_pkg;

  localparam int DEF_SIZE_MANTISSA = 24;
  localparam int DEF_SIZE_EXPONENT = 8;
  localparam int DEF_SIZE_EXC      = 2;
  localparam int DEF_SIZE_INT      = 32;
  localparam int DEF_BIAS          = 127;
  localparam int DEF_SIZE          = DEF_SIZE_MANTISSA + DEF_SIZE_EXPONENT + DEF_SIZE_EXC;

  // Field positions for the default layout
  localparam int EXC_MSB  = DEF_SIZE - 1;
  localparam int EXC_LSB  = DEF_SIZE - DEF_SIZE_EXC;
  localparam int SIGN_POS = EXC_LSB - 1;
  localparam int EXP_MSB  = SIGN_POS - 1;
  localparam int EXP_LSB  = DEF_SIZE_MANTISSA - 1;
  localparam int FRAC_MSB = DEF_SIZE_MANTISSA - 2;

  // Exception-field codes
  localparam int EXC_ZERO   = 0;
  localparam int EXC_NORMAL = 1;
  localparam int EXC_INF    = 2;
  localparam int EXC_NAN    = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_ROUND = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Operand classes resolved at accept time
  typedef enum logic [2:0] {
    CLS_ZERO  = 3'd0,  // exception field zero
    CLS_NAN   = 3'd1,
    CLS_INF   = 3'd2,
    CLS_SAT   = 3'd3,  // finite but out of integer range
    CLS_MIN   = 3'd4,  // exactly the most negative integer
    CLS_TINY  = 3'd5,  // |x| < 0.5, rounds to zero
    CLS_LEFT  = 3'd6,  // magnitude needs a left shift
    CLS_RIGHT = 3'd7   // magnitude needs a right shift with rounding
  } cls_t;

endpackage

// File: rtl/fp_to_int_seq_fp_field_decode.sv
// Combinational field decoder for the FP-to-integer converter.
// Splits the FP word into its fields, removes the exponent bias, classifies
// the operand and produces the shift count the sequential shifter needs.
// Ports:
//   number_i  : FP operand
//   sign      : operand sign
//   mant      : mantissa with the hidden bit restored
//   cls       : operand class (see cls_t)
//   shift_cnt : left-shift count for CLS_LEFT, right-shift count for CLS_RIGHT,
//               zero for every other class
module fp_field_decode
  import fp_to_int_pkg::*;
#(
  parameter int size_mantissa        = DEF_SIZE_MANTISSA,
  parameter int size_exponent        = DEF_SIZE_EXPONENT,
  parameter int size_exception_field = DEF_SIZE_EXC,
  parameter int size_int             = DEF_SIZE_INT,
  parameter int bias                 = DEF_BIAS,
  parameter int size                 = size_mantissa + size_exponent + size_exception_field,
  parameter int cnt_w                = $clog2(size_int + 1)
) (
  input  logic [size-1:0]          number_i,
  output logic                     sign,
  output logic [size_mantissa-1:0] mant,
  output cls_t                     cls,
  output logic [cnt_w-1:0]         shift_cnt
);

  localparam int SIGN_BIT = size - size_exception_field - 1;
  // Two spare bits keep the unbiased exponent signed without wrap
  localparam int EW       = size_exponent + 2;

  localparam logic signed [EW-1:0] BIAS_E     = EW'(bias);
  localparam logic signed [EW-1:0] E_INT_TOP  = EW'(size_int - 1);
  localparam logic signed [EW-1:0] E_MANT_TOP = EW'(size_mantissa - 1);
  localparam logic signed [EW-1:0] E_NEG1     = EW'(-1);

  logic [size_exception_field-1:0] exc;
  logic [size_exponent-1:0]        exp_f;
  logic [size_mantissa-2:0]        frac;
  logic signed [EW-1:0]            e;

  assign exc   = number_i[size-1 -: size_exception_field];
  assign sign  = number_i[SIGN_BIT];
  assign exp_f = number_i[SIGN_BIT-1 -: size_exponent];
  assign frac  = number_i[size_mantissa-2:0];
  assign mant  = {1'b1, frac};
  assign e     = $signed({2'b00, exp_f}) - BIAS_E;

  always_comb begin
    cls       = CLS_ZERO;
    shift_cnt = '0;
    if (exc == size_exception_field'(EXC_NAN)) begin
      cls = CLS_NAN;
    end else if (exc == size_exception_field'(EXC_INF)) begin
      cls = CLS_INF;
    end else if (exc == size_exception_field'(EXC_NORMAL)) begin
      if (e >= E_INT_TOP) begin
        // -2^(size_int-1) is the one value at this exponent that still fits
        cls = (sign && (e == E_INT_TOP) && (frac == '0)) ? CLS_MIN : CLS_SAT;
      end else if (e < E_NEG1) begin
        cls = CLS_TINY;
      end else if (e >= E_MANT_TOP) begin
        cls       = CLS_LEFT;
        shift_cnt = cnt_w'(e - E_MANT_TOP);
      end else begin
        cls       = CLS_RIGHT;
        shift_cnt = cnt_w'(E_MANT_TOP - e);
      end
    end
  end

endmodule

// File: rtl/fp_to_int_seq.sv
// Sequential FP-to-integer converter at the FP datapath exit.
// Accepts one FP operand over valid/ready, aligns its magnitude with a
// one-bit-per-cycle shifter, rounds to nearest-even, applies the sign and
// saturates out-of-range values.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   valid_i / ready_o     : operand handshake (ready_o high only in IDLE)
//   number_i              : FP operand {exception, sign, exponent, fraction}
//   valid_o / ready_i     : result handshake; result held until taken
//   int_o                 : signed integer result
//   overflow_o            : result saturated (out of range or infinity)
//   invalid_o             : operand was NaN
//   inexact_o             : nonzero bits were discarded by rounding
module fp_to_int_seq
  import fp_to_int_pkg::*;
#(
  parameter int size_mantissa        = DEF_SIZE_MANTISSA,
  parameter int size_exponent        = DEF_SIZE_EXPONENT,
  parameter int size_exception_field = DEF_SIZE_EXC,
  parameter int size_int             = DEF_SIZE_INT,
  parameter int bias                 = DEF_BIAS,
  parameter int size                 = size_mantissa + size_exponent + size_exception_field
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic [size-1:0]            number_i,
  output logic                       valid_o,
  input  logic                       ready_i,
  output logic signed [size_int-1:0] int_o,
  output logic                       overflow_o,
  output logic                       invalid_o,
  output logic                       inexact_o
);

  localparam int cnt_w = $clog2(size_int + 1);

  state_t state_q, state_d;

  logic                     dec_sign;
  logic [size_mantissa-1:0] dec_mant;
  cls_t                     dec_cls;
  logic [cnt_w-1:0]         dec_cnt;

  logic [size_int-1:0] mag_q;
  logic [cnt_w-1:0]    cnt_q;
  logic                left_q, neg_q, guard_q, sticky_q;
  logic                ovf_q, inv_q, tiny_q;
  logic                accept;

  // Largest positive magnitude, or 2^(size_int-1) which negates to the minimum
  function automatic logic [size_int-1:0] sat_mag(input logic neg);
    return neg ? {1'b1, {(size_int-1){1'b0}}} : {1'b0, {(size_int-1){1'b1}}};
  endfunction

  // Round-to-nearest-even on the aligned magnitude; size_int > size_mantissa
  // leaves headroom so the increment cannot carry out
  function automatic logic [size_int-1:0] round_rne(input logic [size_int-1:0] m,
                                                    input logic g, input logic s);
    return m + {{(size_int-1){1'b0}}, g & (s | m[0])};
  endfunction

  function automatic logic signed [size_int-1:0] apply_sign(input logic [size_int-1:0] m,
                                                            input logic neg);
    return neg ? -$signed(m) : $signed(m);
  endfunction

  fp_field_decode #(
    .size_mantissa        (size_mantissa),
    .size_exponent        (size_exponent),
    .size_exception_field (size_exception_field),
    .size_int             (size_int),
    .bias                 (bias),
    .size                 (size),
    .cnt_w                (cnt_w)
  ) u_decode (
    .number_i  (number_i),
    .sign      (dec_sign),
    .mant      (dec_mant),
    .cls       (dec_cls),
    .shift_cnt (dec_cnt)
  );

  assign accept = ready_o & valid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Every class passes through ROUND so non-shifting operands share one
  // fixed latency; special values are preloaded as exact magnitudes.
  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    valid_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (valid_i) begin
          state_d = ((dec_cls == CLS_LEFT || dec_cls == CLS_RIGHT) && dec_cnt != '0)
                    ? ST_SHIFT : ST_ROUND;
        end
      end
      ST_SHIFT: if (cnt_q == '0) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_DONE;
      ST_DONE: begin
        valid_o = 1'b1;
        if (ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Accept / shift stage
  always_ff @(posedge clk) begin
    if (accept) begin
      cnt_q    <= dec_cnt;
      left_q   <= (dec_cls == CLS_LEFT);
      neg_q    <= dec_sign;
      guard_q  <= 1'b0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      inv_q    <= 1'b0;
      tiny_q   <= 1'b0;
      mag_q    <= {{(size_int-size_mantissa){1'b0}}, dec_mant};
      unique case (dec_cls)
        CLS_ZERO: begin
          mag_q <= '0;
          neg_q <= 1'b0;
        end
        CLS_NAN: begin
          mag_q <= sat_mag(1'b0);
          neg_q <= 1'b0;
          inv_q <= 1'b1;
        end
        CLS_INF, CLS_SAT: begin
          mag_q <= sat_mag(dec_sign);
          ovf_q <= 1'b1;
        end
        CLS_MIN: mag_q <= sat_mag(1'b1);
        CLS_TINY: begin
          mag_q  <= '0;
          neg_q  <= 1'b0;
          tiny_q <= 1'b1;
        end
        default: ;
      endcase
    end else if (state_q == ST_SHIFT && cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
      if (left_q) begin
        mag_q <= mag_q << 1;
      end else begin
        // Previous guard folds into sticky; the bit leaving becomes guard
        mag_q    <= mag_q >> 1;
        guard_q  <= mag_q[0];
        sticky_q <= sticky_q | guard_q;
      end
    end
  end

  // Round / output stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      int_o      <= '0;
      overflow_o <= 1'b0;
      invalid_o  <= 1'b0;
      inexact_o  <= 1'b0;
    end else if (state_q == ST_ROUND) begin
      int_o      <= apply_sign(round_rne(mag_q, guard_q, sticky_q), neg_q);
      overflow_o <= ovf_q;
      invalid_o  <= inv_q;
      inexact_o  <= tiny_q | guard_q | sticky_q;
    end
  end

endmodule
